// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Fetch gets a zero-latency prediction for PCF; execute resolves
// the branch, trains the table, flags mispredictions and keeps statistics.
module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int CTR_BITS  = 2,
  parameter int STAT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      PCF,
  output logic                 PredTakenF,
  output logic [XLEN-1:0]      PredTargetF,
  input  logic                 UpdateE,
  input  logic                 BranchE,
  input  logic                 JumpE,
  input  logic                 TakenE,
  input  logic [XLEN-1:0]      PCE,
  input  logic [XLEN-1:0]      PCPlus4E,
  input  logic [XLEN-1:0]      PCTargetE,
  input  logic                 PredTakenE,
  input  logic [XLEN-1:0]      PredTargetE,
  input  logic                 InvalidateAll,
  output logic                 MispredictE,
  output logic [XLEN-1:0]      RedirectPCE,
  output logic [STAT_BITS-1:0] BranchCount,
  output logic [STAT_BITS-1:0] MispredictCount
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0]  CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  // Per-entry state. Valid, counter and jump flag are reset; tag and target
  // are plain storage whose contents only matter once valid is set.
  logic [ENTRIES-1:0]  valid_vec;
  logic [ENTRIES-1:0]  jump_vec;
  logic [CTR_BITS-1:0] ctr_vec    [ENTRIES];
  logic [TAG_W-1:0]    tag_mem    [ENTRIES];
  logic [XLEN-1:0]     target_mem [ENTRIES];

  logic [STAT_BITS-1:0] branch_cnt_reg;
  logic [STAT_BITS-1:0] mispredict_cnt_reg;

  // Instruction alignment bits never take part in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  // Fetch-side lookup
  logic [IDX-1:0]   f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx       = PCF[IDX+1:2];
  assign f_tag       = PCF[XLEN-1:IDX+2];
  assign f_hit       = valid_vec[f_idx] && (tag_mem[f_idx] == f_tag);
  assign PredTakenF  = f_hit && (jump_vec[f_idx] || ctr_vec[f_idx][CTR_BITS-1]);
  assign PredTargetF = PredTakenF ? target_mem[f_idx] : '0;

  // Execute-side lookup of the resolving instruction
  logic [IDX-1:0]      e_idx;
  logic [TAG_W-1:0]    e_tag;
  logic                e_hit;
  logic [CTR_BITS-1:0] e_ctr;
  logic                br;
  logic                alias_hit;
  logic                alloc;
  logic                ctr_we;
  logic                entry_we;
  logic                kill;
  logic [CTR_BITS-1:0] ctr_next;

  assign e_idx = PCE[IDX+1:2];
  assign e_tag = PCE[XLEN-1:IDX+2];
  assign e_hit = valid_vec[e_idx] && (tag_mem[e_idx] == e_tag);
  assign e_ctr = ctr_vec[e_idx];

  assign br        = UpdateE && (BranchE || JumpE);
  // A non-branch that fetch predicted taken is a stale/aliased BTB entry.
  assign alias_hit = UpdateE && !br && PredTakenE;
  assign alloc     = br && !e_hit && (TakenE || JumpE);
  assign ctr_we    = br && (e_hit || alloc);
  assign entry_we  = br && ((e_hit && TakenE) || alloc);
  assign kill      = alias_hit && e_hit;

  // Next counter value: fresh allocation, saturating increment or decrement
  always_comb begin
    ctr_next = e_ctr;
    if (alloc) begin
      ctr_next = JumpE ? CTR_MAX : CTR_WEAK;
    end else if (TakenE) begin
      ctr_next = (e_ctr == CTR_MAX) ? e_ctr : e_ctr + 1'b1;
    end else begin
      ctr_next = (e_ctr == '0) ? e_ctr : e_ctr - 1'b1;
    end
  end

  // Misprediction detection for the resolving instruction
  always_comb begin
    MispredictE = 1'b0;
    if (br) begin
      MispredictE = (TakenE != PredTakenE) ||
                    (TakenE && PredTakenE && (PredTargetE != PCTargetE));
    end else if (alias_hit) begin
      MispredictE = 1'b1;
    end
  end

  assign RedirectPCE = (br && TakenE) ? PCTargetE : PCPlus4E;

  // Per-entry control state; InvalidateAll overrides any same-cycle write
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic                sel;
    logic                valid_reg;
    logic                jump_reg;
    logic [CTR_BITS-1:0] ctr_reg;

    assign sel           = (e_idx == IDX'(gi));
    assign valid_vec[gi] = valid_reg;
    assign jump_vec[gi]  = jump_reg;
    assign ctr_vec[gi]   = ctr_reg;

    // Valid bit, direction counter and jump flag for this entry
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_reg <= 1'b0;
        jump_reg  <= 1'b0;
        ctr_reg   <= '0;
      end else begin
        if (InvalidateAll) begin
          valid_reg <= 1'b0;
        end else if (sel && alloc) begin
          valid_reg <= 1'b1;
        end else if (sel && kill) begin
          valid_reg <= 1'b0;
        end
        if (sel && ctr_we) begin
          ctr_reg <= ctr_next;
        end
        if (sel && entry_we) begin
          jump_reg <= JumpE;
        end
      end
    end
  end

  // Tag and target storage, written on allocation or taken hit
  always_ff @(posedge clk) begin
    if (entry_we) begin
      tag_mem[e_idx]    <= e_tag;
      target_mem[e_idx] <= PCTargetE;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else begin
      if (br && (branch_cnt_reg != STAT_MAX)) begin
        branch_cnt_reg <= branch_cnt_reg + 1'b1;
      end
      if (MispredictE && (mispredict_cnt_reg != STAT_MAX)) begin
        mispredict_cnt_reg <= mispredict_cnt_reg + 1'b1;
      end
    end
  end

  assign BranchCount     = branch_cnt_reg;
  assign MispredictCount = mispredict_cnt_reg;

endmodule
